// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the rv32i fetch stage: NOP encoding, default reset PC,
// FSM state encoding and the {inst, pc} slot type carried by the hold buffer.
package rv32i_fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2,
        S_ERR     = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_slot_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/rv32i_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface rv32i_fetch_if;
    logic [31:0] iaddr;
    logic        stb_inst;
    logic        ack_inst;
    logic [31:0] inst;

    modport master (output iaddr, output stb_inst, input ack_inst, input inst);
    modport slave  (input iaddr, input stb_inst, output ack_inst, output inst);
endinterface

// File: rtl/rv32i_fetch_holdbuf.sv
// One-entry {inst, pc} skid buffer for the fetch stage. Clear wins over load,
// load wins over drain.
module rv32i_fetch_holdbuf
    import rv32i_fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  fetch_slot_t i_slot,
    output logic        o_valid,
    output fetch_slot_t o_slot
);

    logic        valid_q, valid_d;
    fetch_slot_t slot_q, slot_d;

    // Buffer occupancy and contents for the next cycle
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            slot_d  = i_slot;
        end else if (i_drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            slot_q  <= {32'h0000_0000, 32'h0000_0000};
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign o_valid = valid_q;
    assign o_slot  = slot_q;

endmodule

// File: rtl/rv32i_fetch.sv
// rv32i instruction-fetch stage: single-outstanding imem requests, redirects,
// stall/flush handling. Optional trap on misaligned redirect: RV32I_FETCH_MISALIGN_TRAP_EN.
module rv32i_fetch
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rv32i_fetch_if.master        imem,
    input  logic                 i_writeback_change_pc,
    input  logic [31:0]          i_writeback_next_pc,
    input  logic                 i_alu_change_pc,
    input  logic [31:0]          i_alu_next_pc,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic [31:0]          o_inst,
    output logic [31:0]          o_pc,
    output logic                 o_ce,
    output logic                 o_misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  iaddr_q, iaddr_d;
    logic [31:0]  out_inst_q, out_inst_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic         out_ce_q, out_ce_d;
    logic         out_mis_q, out_mis_d;

    logic         redir_s, redir_mis_s, stb_s, ack_s;
    logic [31:0]  raw_tgt_s, redir_tgt_s;
    logic         buf_load_s, buf_drain_s, buf_clear_s, buf_valid_s;
    fetch_slot_t  buf_in_s, buf_out_s;

    assign redir_s   = i_writeback_change_pc | i_alu_change_pc;
    assign raw_tgt_s = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    assign redir_tgt_s = raw_tgt_s;
    assign redir_mis_s = redir_s && (raw_tgt_s[1:0] != 2'b00);
`else
    assign redir_tgt_s = raw_tgt_s & 32'hFFFF_FFFC;
    assign redir_mis_s = 1'b0;
`endif

    // Strobe is gated by reset so an abandoned request drops immediately
    assign stb_s    = ((state_q == S_REQ) || (state_q == S_DISCARD)) && !i_rst;
    assign ack_s    = stb_s && imem.ack_inst;
    assign buf_in_s = {imem.inst, iaddr_q};

    rv32i_fetch_holdbuf u_holdbuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (buf_load_s),
        .i_drain (buf_drain_s),
        .i_clear (buf_clear_s),
        .i_slot  (buf_in_s),
        .o_valid (buf_valid_s),
        .o_slot  (buf_out_s)
    );

    // Next-state, fetch address and output-slot update
    always_comb begin
        state_d     = state_q;
        iaddr_d     = iaddr_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_ce_d    = out_ce_q;
        out_mis_d   = out_mis_q;
        buf_load_s  = 1'b0;
        buf_drain_s = 1'b0;
        buf_clear_s = 1'b0;

        if (redir_s) begin
            // A redirect overrides ack, stall and drain, and flushes the slot
            buf_clear_s = 1'b1;
            iaddr_d     = redir_tgt_s;
            out_inst_d  = NOP_INST;
            out_ce_d    = 1'b0;
            out_mis_d   = 1'b0;
            if (redir_mis_s) begin
                state_d   = S_ERR;
                out_ce_d  = 1'b1;
                out_mis_d = 1'b1;
                out_pc_d  = redir_tgt_s;
            end else if (stb_s && !ack_s) begin
                state_d = S_DISCARD;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            if (i_flush) begin
                out_inst_d = NOP_INST;
                out_ce_d   = 1'b0;
                out_mis_d  = 1'b0;
            end else if (!i_stall) begin
                out_ce_d = 1'b0;
            end else begin
                out_ce_d = out_ce_q;
            end

            case (state_q)
                S_REQ: begin
                    if (ack_s) begin
                        iaddr_d = pc_plus4(iaddr_q);
                        if ((!out_ce_q || !i_stall) && !i_flush) begin
                            out_inst_d = imem.inst;
                            out_pc_d   = iaddr_q;
                            out_ce_d   = 1'b1;
                            out_mis_d  = 1'b0;
                        end else begin
                            buf_load_s = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_DISCARD: begin
                    state_d = ack_s ? S_REQ : S_DISCARD;
                end
                S_HOLD: begin
                    if (!buf_valid_s) begin
                        state_d = S_REQ;
                    end else if (!i_stall && !i_flush) begin
                        out_inst_d  = buf_out_s.inst;
                        out_pc_d    = buf_out_s.pc;
                        out_ce_d    = 1'b1;
                        out_mis_d   = 1'b0;
                        buf_drain_s = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // Architectural fetch state and output slot registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_REQ;
            iaddr_q    <= PC_RESET;
            out_inst_q <= NOP_INST;
            out_pc_q   <= 32'h0000_0000;
            out_ce_q   <= 1'b0;
            out_mis_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            iaddr_q    <= iaddr_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            out_ce_q   <= out_ce_d;
            out_mis_q  <= out_mis_d;
        end
    end

    assign imem.iaddr    = iaddr_q;
    assign imem.stb_inst = stb_s;
    assign o_inst        = out_inst_q;
    assign o_pc          = out_pc_q;
    assign o_ce          = out_ce_q;
    assign o_misaligned  = out_mis_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_rv32i_fetch;
    import rv32i_fetch_pkg::*;

    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_chg, alu_chg, stall, flush;
    logic [31:0] wb_pc, alu_pc;
    logic [31:0] o_inst, o_pc;
    logic        o_ce, o_mis;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int mem_cnt = 0;

    always #5 clk = ~clk;

    rv32i_fetch_if imem();

    rv32i_fetch #(.PC_RESET(PC_RST)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .imem                  (imem),
        .i_writeback_change_pc (wb_chg),
        .i_writeback_next_pc   (wb_pc),
        .i_alu_change_pc       (alu_chg),
        .i_alu_next_pc         (alu_pc),
        .i_stall               (stall),
        .i_flush               (flush),
        .o_inst                (o_inst),
        .o_pc                  (o_pc),
        .o_ce                  (o_ce),
        .o_misaligned          (o_mis)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: acknowledges a strobe after mem_lat extra cycles, data derived from address
    always @(negedge clk) begin
        #2;
        if (imem.stb_inst === 1'b1) begin
            if (mem_cnt >= mem_lat) begin
                imem.ack_inst = 1'b1;
                imem.inst     = mem_word(imem.iaddr);
                mem_cnt       = 0;
            end else begin
                imem.ack_inst = 1'b0;
                mem_cnt++;
            end
        end else begin
            imem.ack_inst = 1'b0;
            mem_cnt       = 0;
        end
    end

    // Transaction-level model: fetch address, stale flag, FIFO buffer, output slot
    logic [31:0] m_addr, m_inst, m_pc;
    logic        m_ce, m_mis, m_stale, m_err;
    logic [63:0] m_buf[$];

    task automatic model_step();
        logic        redir, mis, stb, acc, have_word, placed;
        logic [31:0] tgt, w_inst, w_pc;
        if (rst) begin
            m_addr = PC_RST; m_inst = NOP_INST; m_pc = 32'h0; m_ce = 1'b0;
            m_mis = 1'b0; m_stale = 1'b0; m_err = 1'b0; m_buf.delete();
            return;
        end
        stb   = !m_err && (m_buf.size() == 0);
        acc   = stb && imem.ack_inst;
        redir = wb_chg || alu_chg;
        tgt   = wb_chg ? wb_pc : alu_pc;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        mis = (tgt % 4) != 0;
`else
        mis = 1'b0;
        tgt = tgt - (tgt % 4);
`endif
        if (redir) begin
            m_buf.delete();
            m_addr = tgt;
            m_inst = NOP_INST;
            if (mis) begin
                m_err = 1'b1; m_stale = 1'b0; m_ce = 1'b1; m_mis = 1'b1; m_pc = tgt;
            end else begin
                m_err = 1'b0; m_stale = stb && !acc; m_ce = 1'b0; m_mis = 1'b0;
            end
            return;
        end
        have_word = acc && !m_stale;
        if (acc) m_stale = 1'b0;
        w_inst = 32'h0; w_pc = 32'h0;
        if (have_word) begin
            w_inst = imem.inst; w_pc = m_addr; m_addr = m_addr + 32'd4;
        end
        placed = 1'b0;
        if (flush) begin
            m_ce = 1'b0; m_inst = NOP_INST; m_mis = 1'b0;
        end else if (m_buf.size() != 0 && !stall) begin
            {m_inst, m_pc} = m_buf.pop_front(); m_ce = 1'b1; m_mis = 1'b0;
        end else if (have_word && (!m_ce || !stall)) begin
            m_inst = w_inst; m_pc = w_pc; m_ce = 1'b1; m_mis = 1'b0; placed = 1'b1;
        end else if (!stall) begin
            m_ce = 1'b0;
        end
        if (have_word && !placed) m_buf.push_back({w_inst, w_pc});
    endtask

    // Compare process: advance the model with this cycle's inputs, then check every output
    always @(negedge clk) begin
        model_step();
        chk("iaddr", imem.iaddr, m_addr);
        chk1("stb", imem.stb_inst, !rst && !m_err && (m_buf.size() == 0));
        chk("o_inst", o_inst, m_inst);
        chk("o_pc", o_pc, m_pc);
        chk1("o_ce", o_ce, m_ce);
        chk1("o_misaligned", o_mis, m_mis);
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pc(input string name, input logic [31:0] pc, input int budget);
        int n = 0;
        while (!(o_ce === 1'b1 && o_pc === pc) && n < budget) begin
            nxt();
            n++;
        end
        chk1({name, "_ce"}, o_ce, 1'b1);
        chk({name, "_pc"}, o_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_chg = 1'b0; wb_pc = 32'h0; alu_chg = 1'b0; alu_pc = 32'h0;
        stall = 1'b0; flush = 1'b0; mem_lat = 0;
        nxt(); nxt();
        chk("rst_iaddr", imem.iaddr, 32'h0000_0100);
        chk("rst_inst", o_inst, 32'h0000_0013);
        chk("rst_pc", o_pc, 32'h0000_0000);
        chk1("rst_ce", o_ce, 1'b0);
        chk1("rst_stb", imem.stb_inst, 1'b0);

        // Zero-wait streaming from reset
        rst = 1'b0;
        nxt(); chk1("seq0_ce", o_ce, 1'b1); chk("seq0_pc", o_pc, 32'h0000_0100);
        nxt(); chk("seq1_pc", o_pc, 32'h0000_0104);
        nxt(); chk("seq2_pc", o_pc, 32'h0000_0108);

        // ALU redirect while a slow request to 0x10c is pending
        mem_lat = 3;
        nxt();
        alu_chg = 1'b1; alu_pc = 32'h0000_0200;
        nxt(); alu_chg = 1'b0;
        chk("redir_iaddr", imem.iaddr, 32'h0000_0200);
        wait_pc("redir", 32'h0000_0200, 20);
        chk("redir_inst", o_inst, 32'h5A00_0200);

        // Writeback wins over ALU in the same cycle
        mem_lat = 0;
        wb_chg = 1'b1; wb_pc = 32'h0000_0080; alu_chg = 1'b1; alu_pc = 32'h0000_0300;
        nxt(); wb_chg = 1'b0; alu_chg = 1'b0;
        chk("prio_iaddr", imem.iaddr, 32'h0000_0080);
        chk1("prio_ce", o_ce, 1'b0);
        nxt(); chk("prio_pc", o_pc, 32'h0000_0080);

        // Stall for 4 cycles while an ack arrives
        wait_pc("pre_stall", 32'h0000_0088, 10);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("stall_pc", o_pc, 32'h0000_0088);
            chk1("stall_ce", o_ce, 1'b1);
            chk1("stall_stb", imem.stb_inst, 1'b0);
        end
        stall = 1'b0;
        nxt(); chk("drain_pc", o_pc, 32'h0000_008C); chk("drain_inst", o_inst, 32'h5A00_008C);
        nxt(); chk("post_drain_pc", o_pc, 32'h0000_0090);

        // Flush under stall
        wait_pc("pre_flush", 32'h0000_00A0, 10);
        stall = 1'b1; flush = 1'b1;
        nxt(); stall = 1'b0; flush = 1'b0;
        chk1("flush_ce", o_ce, 1'b0);
        chk("flush_inst", o_inst, 32'h0000_0013);
        nxt(); chk("flush_next_pc", o_pc, 32'h0000_00A4);

        // Address wrap
        alu_chg = 1'b1; alu_pc = 32'hFFFF_FFF8;
        nxt(); alu_chg = 1'b0;
        wait_pc("wrap_hi", 32'hFFFF_FFFC, 10);
        nxt(); chk("wrap_pc", o_pc, 32'h0000_0000);

        // Misaligned redirect target
        alu_chg = 1'b1; alu_pc = 32'h0000_0202;
        nxt(); alu_chg = 1'b0;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        chk1("mis_flag", o_mis, 1'b1);
        chk1("mis_ce", o_ce, 1'b1);
        chk("mis_pc", o_pc, 32'h0000_0202);
        chk("mis_inst", o_inst, 32'h0000_0013);
        chk1("mis_stb", imem.stb_inst, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk1("mis_hold_flag", o_mis, 1'b1);
            chk1("mis_hold_stb", imem.stb_inst, 1'b0);
        end
        wb_chg = 1'b1; wb_pc = 32'h0000_0010;
        nxt(); wb_chg = 1'b0;
        chk("mis_exit_iaddr", imem.iaddr, 32'h0000_0010);
        chk1("mis_exit_flag", o_mis, 1'b0);
        wait_pc("mis_exit", 32'h0000_0010, 10);
`else
        chk("align_iaddr", imem.iaddr, 32'h0000_0200);
        chk1("align_flag", o_mis, 1'b0);
        wait_pc("align", 32'h0000_0200, 10);
`endif

        // Reset while a request is outstanding
        mem_lat = 2;
        nxt();
        rst = 1'b1;
        nxt(); rst = 1'b0; mem_lat = 0;
        chk("midrst_iaddr", imem.iaddr, 32'h0000_0100);
        chk1("midrst_ce", o_ce, 1'b0);
        nxt(); chk("midrst_pc", o_pc, 32'h0000_0100);

        // Mixed traffic checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            mem_lat = $urandom_range(0, 2);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            alu_chg = ($urandom_range(0, 11) == 0);
            alu_pc  = 32'($urandom_range(0, 4095));
            wb_chg  = ($urandom_range(0, 23) == 0);
            wb_pc   = 32'($urandom_range(0, 4095));
            nxt();
        end
        stall = 1'b0; flush = 1'b0; alu_chg = 1'b0; wb_chg = 1'b0;
        nxt(); nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
